// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module  : wb_port_arbiter_if
// Brief   : Bus bundle for the two-requester register-file write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              Req1;
    logic [4:0]        Addr1;
    logic [DATA_W-1:0] Data1;
    logic              Ack1;

    logic              Req2;
    logic [4:0]        Addr2;
    logic [DATA_W-1:0] Data2;
    logic              Ack2;

    logic              Hold;

    logic              RegWrite;
    logic [4:0]        WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic              Sel;
    logic [CNT_W-1:0]  ConflictCnt;

    // Arbiter side
    modport slave (
        input  Req1, Addr1, Data1,
        input  Req2, Addr2, Data2,
        input  Hold,
        output Ack1, Ack2,
        output RegWrite, WriteAddr, WriteData, Sel, ConflictCnt
    );

    // Requester / register-file side
    modport master (
        output Req1, Addr1, Data1,
        output Req2, Addr2, Data2,
        output Hold,
        input  Ack1, Ack2,
        input  RegWrite, WriteAddr, WriteData, Sel, ConflictCnt
    );
endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module  : wb_port_arbiter
// Brief   : Round-robin arbiter merging two write requesters onto one
//           register-file write port, with a saturating conflict counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  wire logic        Clk,
    input  wire logic        Resetn,
    wb_port_arbiter_if.slave bus
);

    localparam logic c_REQ1 = 1'b0;
    localparam logic c_REQ2 = 1'b1;

    logic              last_q,     last_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        waddr_q,    waddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              sel_q,      sel_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              w_grant1;
    logic              w_grant2;
    logic              w_xfer;
    logic              w_both;
    logic [4:0]        w_addr;
    logic [DATA_W-1:0] w_data;

    // Grants are gated by Resetn so nothing is acknowledged while in reset.
    always_comb begin
        w_both   = bus.Req1 & bus.Req2;
        w_grant1 = Resetn & ~bus.Hold & bus.Req1 & (~bus.Req2 | (last_q == c_REQ2));
        w_grant2 = Resetn & ~bus.Hold & bus.Req2 & (~bus.Req1 | (last_q == c_REQ1));
        w_xfer   = w_grant1 | w_grant2;
        w_addr   = w_grant2 ? bus.Addr2 : bus.Addr1;
        w_data   = w_grant2 ? bus.Data2 : bus.Data1;
    end

    always_comb begin
        last_d     = last_q;
        regwrite_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        if (w_xfer) begin
            last_d     = w_grant2 ? c_REQ2 : c_REQ1;
            waddr_d    = w_addr;
            wdata_d    = w_data;
            sel_d      = w_grant2;
            // Writes to register zero are acknowledged but never committed.
            regwrite_d = (w_addr != 5'd0);
            if (w_both && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            last_q     <= c_REQ2;
            regwrite_q <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= {DATA_W{1'b0}};
            sel_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            last_q     <= last_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.Ack1        = w_grant1;
    assign bus.Ack2        = w_grant2;
    assign bus.RegWrite    = regwrite_q;
    assign bus.WriteAddr   = waddr_q;
    assign bus.WriteData   = wdata_q;
    assign bus.Sel         = sel_q;
    assign bus.ConflictCnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module  : tb_wb_port_arbiter
// Brief   : Self-checking bench for wb_port_arbiter (default and CNT_W=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    logic Clk    = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clk = ~Clk;

    wb_port_arbiter_if #(.DATA_W(32), .CNT_W(8)) bus  ();
    wb_port_arbiter_if #(.DATA_W(32), .CNT_W(2)) bus2 ();

    wb_port_arbiter #(.DATA_W(32), .CNT_W(8)) dut  (.Clk(Clk), .Resetn(Resetn), .bus(bus));
    wb_port_arbiter #(.DATA_W(32), .CNT_W(2)) dut2 (.Clk(Clk), .Resetn(Resetn), .bus(bus2));

    typedef struct packed {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        sel;
        logic [7:0]  cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic        m_last;
    logic        m_rw;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_sel;
    logic [7:0]  m_cnt;
    logic [1:0]  m_cnt2;

    task automatic set_in(input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic r2, input logic [4:0] a2, input logic [31:0] d2,
                          input logic h);
        bus.Req1  = r1; bus.Addr1  = a1; bus.Data1  = d1;
        bus.Req2  = r2; bus.Addr2  = a2; bus.Data2  = d2; bus.Hold  = h;
        bus2.Req1 = r1; bus2.Addr1 = a1; bus2.Data1 = d1;
        bus2.Req2 = r2; bus2.Addr2 = a2; bus2.Data2 = d2; bus2.Hold = h;
    endtask

    task automatic model_reset();
        m_last = 1'b1; m_rw = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        m_sel  = 1'b0; m_cnt = 8'd0; m_cnt2 = 2'd0;
        sb.delete();
    endtask

    // Reference arbitration: returns {ack2, ack1} and queues the next-edge outputs.
    task automatic predict(output logic [1:0] ea);
        exp_t e;
        logic a1, a2;
        a1 = !bus.Hold && bus.Req1 && (!bus.Req2 || m_last);
        a2 = !bus.Hold && bus.Req2 && (!bus.Req1 || !m_last);
        if (a1 || a2) begin
            m_addr = a2 ? bus.Addr2 : bus.Addr1;
            m_data = a2 ? bus.Data2 : bus.Data1;
            m_sel  = a2;
            m_rw   = (m_addr != 5'd0);
            m_last = a2;
            if (bus.Req1 && bus.Req2) begin
                if (m_cnt  != 8'hFF) m_cnt  = m_cnt + 8'd1;
                if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
            end
        end else begin
            m_rw = 1'b0;
        end
        e.rw = m_rw; e.addr = m_addr; e.data = m_data; e.sel = m_sel;
        e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
        ea = {a2, a1};
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        Resetn = 1'b0;
        #2;
        Resetn = 1'b1;
        model_reset();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        logic [1:0] ea;
        exp_t e;
        Resetn = 1'b0;
        set_in(1, 5'd3, 32'h1111_0003, 1, 5'd7, 32'h2222_0007, 0);
        #2;
        checks++;
        if ({bus.Ack2, bus.Ack1} !== 2'b00 || {bus2.Ack2, bus2.Ack1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ack got=%b/%b exp=00", {bus.Ack2, bus.Ack1}, {bus2.Ack2, bus2.Ack1});
        end
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd0 || bus.WriteData !== 32'd0 ||
            bus.Sel !== 1'b0 || bus.ConflictCnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_out got rw=%b a=%0d d=%h s=%b c=%0d exp all zero",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.Sel, bus.ConflictCnt);
        end
        model_reset();
        @(posedge Clk); #1;
        Resetn = 1'b1;
        // Requests held across release: requester 1 must win first.
        #1; predict(ea);
        checks++;
        if (bus.Ack1 !== 1'b1 || bus.Ack2 !== 1'b0 || {bus.Ack2, bus.Ack1} !== ea) begin
            failures++;
            $display("FAIL reset_release_ack got=%b exp=01", {bus.Ack2, bus.Ack1});
        end
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.RegWrite !== e.rw || bus.WriteAddr !== 5'd3 || bus.Sel !== 1'b0 || bus.ConflictCnt !== e.cnt) begin
            failures++;
            $display("FAIL reset_release_out got rw=%b a=%0d s=%b c=%0d exp rw=1 a=3 s=0 c=%0d",
                     bus.RegWrite, bus.WriteAddr, bus.Sel, bus.ConflictCnt, e.cnt);
        end
    endtask

    task automatic test_single();
        logic [1:0] ea;
        exp_t e;
        do_reset();
        set_in(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
        #1; predict(ea);
        checks++;
        if ({bus.Ack2, bus.Ack1} !== 2'b01 || ea !== 2'b01) begin
            failures++;
            $display("FAIL single_ack got=%b exp=01", {bus.Ack2, bus.Ack1});
        end
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd5 || bus.WriteData !== 32'hDEADBEEF ||
            bus.Sel !== 1'b0 || bus.RegWrite !== e.rw) begin
            failures++;
            $display("FAIL single_out got rw=%b a=%0d d=%h s=%b exp rw=1 a=5 d=deadbeef s=0",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.Sel);
        end
        // Idle edge: RegWrite drops, other outputs hold.
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        #1; predict(ea);
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd5 || bus.WriteData !== 32'hDEADBEEF || bus.Sel !== e.sel) begin
            failures++;
            $display("FAIL idle_hold got rw=%b a=%0d d=%h exp rw=0 a=5 d=deadbeef",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData);
        end
    endtask

    task automatic test_conflict();
        logic [1:0] ea;
        exp_t e;
        do_reset();
        set_in(1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'hBBBB_0007, 0);
        for (int i = 0; i < 4; i++) begin
            #1; predict(ea);
            checks++;
            if ({bus.Ack2, bus.Ack1} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || {bus.Ack2, bus.Ack1} !== ea) begin
                failures++;
                $display("FAIL conflict_ack[%0d] got=%b model=%b", i, {bus.Ack2, bus.Ack1}, ea);
            end
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.WriteAddr !== ((i % 2 == 0) ? 5'd3 : 5'd7) || bus.Sel !== (i % 2 == 1) ||
                bus.RegWrite !== 1'b1 || bus.WriteData !== e.data || bus.ConflictCnt !== e.cnt) begin
                failures++;
                $display("FAIL conflict_out[%0d] got a=%0d s=%b rw=%b d=%h c=%0d exp d=%h c=%0d",
                         i, bus.WriteAddr, bus.Sel, bus.RegWrite, bus.WriteData, bus.ConflictCnt, e.data, e.cnt);
            end
        end
        checks++;
        if (bus.ConflictCnt !== 8'd4) begin
            failures++;
            $display("FAIL conflict_cnt got=%0d exp=4", bus.ConflictCnt);
        end
    endtask

    task automatic test_zero_drop();
        logic [1:0] ea;
        exp_t e;
        set_in(0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_1234, 0);
        #1; predict(ea);
        checks++;
        if ({bus.Ack2, bus.Ack1} !== 2'b10 || ea !== 2'b10) begin
            failures++;
            $display("FAIL zero_ack got=%b exp=10", {bus.Ack2, bus.Ack1});
        end
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd0 || bus.Sel !== 1'b1 ||
            bus.WriteData !== e.data || bus.ConflictCnt !== 8'd4) begin
            failures++;
            $display("FAIL zero_out got rw=%b a=%0d s=%b d=%h c=%0d exp rw=0 a=0 s=1 c=4",
                     bus.RegWrite, bus.WriteAddr, bus.Sel, bus.WriteData, bus.ConflictCnt);
        end
    endtask

    task automatic test_hold();
        logic [1:0] ea;
        exp_t e;
        set_in(1, 5'd11, 32'hC0DE_0011, 1, 5'd12, 32'hC0DE_0012, 1);
        for (int i = 0; i < 3; i++) begin
            #1; predict(ea);
            checks++;
            if ({bus.Ack2, bus.Ack1} !== 2'b00 || ea !== 2'b00) begin
                failures++;
                $display("FAIL hold_ack[%0d] got=%b exp=00", i, {bus.Ack2, bus.Ack1});
            end
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.RegWrite !== 1'b0 || bus.ConflictCnt !== 8'd4 || bus.WriteAddr !== e.addr) begin
                failures++;
                $display("FAIL hold_out[%0d] got rw=%b c=%0d a=%0d exp rw=0 c=4 a=%0d",
                         i, bus.RegWrite, bus.ConflictCnt, bus.WriteAddr, e.addr);
            end
        end
        set_in(1, 5'd11, 32'hC0DE_0011, 1, 5'd12, 32'hC0DE_0012, 0);
        #1; predict(ea);
        checks++;
        if ({bus.Ack2, bus.Ack1} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release_ack got=%b exp=01", {bus.Ack2, bus.Ack1});
        end
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.WriteAddr !== 5'd11 || bus.RegWrite !== 1'b1 || bus.ConflictCnt !== e.cnt) begin
            failures++;
            $display("FAIL hold_release_out got a=%0d rw=%b c=%0d exp a=11 rw=1 c=%0d",
                     bus.WriteAddr, bus.RegWrite, bus.ConflictCnt, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ea;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 5'd0, 32'd0, 1, 5'(i + 20), 32'h5A5A_0000 + 32'(i), 0);
            #1; predict(ea);
            checks++;
            if ({bus.Ack2, bus.Ack1} !== 2'b10) begin
                failures++;
                $display("FAIL b2b_ack[%0d] got=%b exp=10", i, {bus.Ack2, bus.Ack1});
            end
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'(i + 20) ||
                bus.WriteData !== 32'h5A5A_0000 + 32'(i) || bus.Sel !== 1'b1 || bus.ConflictCnt !== e.cnt) begin
                failures++;
                $display("FAIL b2b_out[%0d] got rw=%b a=%0d d=%h s=%b", i,
                         bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.Sel);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] ea;
        exp_t e;
        do_reset();
        set_in(1, 5'd1, 32'h0000_0001, 1, 5'd2, 32'h0000_0002, 0);
        for (int i = 0; i < 7; i++) begin
            #1; predict(ea);
            checks++;
            if ({bus2.Ack2, bus2.Ack1} !== ea) begin
                failures++;
                $display("FAIL sat_ack[%0d] got=%b exp=%b", i, {bus2.Ack2, bus2.Ack1}, ea);
            end
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus2.ConflictCnt !== e.cnt2 || bus.ConflictCnt !== e.cnt) begin
                failures++;
                $display("FAIL sat_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i,
                         bus2.ConflictCnt, bus.ConflictCnt, e.cnt2, e.cnt);
            end
        end
        checks++;
        if (bus2.ConflictCnt !== 2'd3 || bus.ConflictCnt !== 8'd7) begin
            failures++;
            $display("FAIL sat_final got=%0d/%0d exp=3/7", bus2.ConflictCnt, bus.ConflictCnt);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] ea;
        exp_t e;
        set_in(0, 5'd0, 32'd0, 1, 5'd9, 32'h0909_0909, 0);
        #1; predict(ea);
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd9 || bus.Sel !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got rw=%b a=%0d s=%b exp rw=1 a=9 s=1", bus.RegWrite, bus.WriteAddr, bus.Sel);
        end
        set_in(1, 5'd4, 32'h0404_0404, 1, 5'd6, 32'h0606_0606, 0);
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd0 || bus.Sel !== 1'b0 ||
            bus.ConflictCnt !== 8'd0 || bus2.ConflictCnt !== 2'd0 || {bus.Ack2, bus.Ack1} !== 2'b00) begin
            failures++;
            $display("FAIL async_reset got rw=%b a=%0d s=%b c=%0d ack=%b exp all zero",
                     bus.RegWrite, bus.WriteAddr, bus.Sel, bus.ConflictCnt, {bus.Ack2, bus.Ack1});
        end
        model_reset();
        #1;
        Resetn = 1'b1;
        #1; predict(ea);
        checks++;
        if ({bus.Ack2, bus.Ack1} !== 2'b01) begin
            failures++;
            $display("FAIL async_first_grant got=%b exp=01", {bus.Ack2, bus.Ack1});
        end
        @(posedge Clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.WriteAddr !== 5'd4 || bus.ConflictCnt !== 8'd1 || bus.RegWrite !== e.rw) begin
            failures++;
            $display("FAIL async_first_out got a=%0d c=%0d exp a=4 c=1", bus.WriteAddr, bus.ConflictCnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] ea;
        exp_t e;
        logic r1, r2, h;
        logic [4:0] a1, a2;
        logic [31:0] d1, d2;
        r1 = 0; r2 = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < 300; i++) begin
            // A pending request stays stable until acknowledged.
            if (!r1) begin r1 = ($urandom_range(0, 3) != 0); a1 = 5'($urandom_range(0, 31)); d1 = $urandom; end
            if (!r2) begin r2 = ($urandom_range(0, 3) != 0); a2 = 5'($urandom_range(0, 31)); d2 = $urandom; end
            h = ($urandom_range(0, 4) == 0);
            set_in(r1, a1, d1, r2, a2, d2, h);
            #1; predict(ea);
            checks++;
            if ({bus.Ack2, bus.Ack1} !== ea || {bus2.Ack2, bus2.Ack1} !== ea) begin
                failures++;
                $display("FAIL rand_ack[%0d] got=%b exp=%b", i, {bus.Ack2, bus.Ack1}, ea);
            end
            @(posedge Clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.RegWrite !== e.rw || bus.WriteAddr !== e.addr || bus.WriteData !== e.data ||
                bus.Sel !== e.sel || bus.ConflictCnt !== e.cnt || bus2.ConflictCnt !== e.cnt2) begin
                failures++;
                $display("FAIL rand_out[%0d] got rw=%b a=%0d d=%h s=%b c=%0d exp rw=%b a=%0d d=%h s=%b c=%0d",
                         i, bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.Sel, bus.ConflictCnt,
                         e.rw, e.addr, e.data, e.sel, e.cnt);
            end
            if (ea[0]) r1 = 1'b0;
            if (ea[1]) r2 = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_single();
        test_conflict();
        test_zero_drop();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
